// File: rtl/bitgen.sv
// Builds the canonical 64-bit word a bit-count unit maps back to a given count (CLZ/CTZ/CNT, 64/32).
// Latency: 8 cycles from accept to dout_valid for legal requests, 1 cycle for illegal ones.
// Backpressure: one request in flight; din_ready only in IDLE, result held in DONE until dout_ready.
module bitgen (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic [6:0]  din_cnt,
    input  logic [2:0]  din_func,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic [63:0] dout_data,
    output logic        dout_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] FN_CLZ64 = 3'b000;
    localparam logic [2:0] FN_CLZ32 = 3'b001;
    localparam logic [2:0] FN_CTZ64 = 3'b010;
    localparam logic [2:0] FN_CTZ32 = 3'b011;
    localparam logic [2:0] FN_CNT64 = 3'b100;
    localparam logic [2:0] FN_CNT32 = 3'b101;

    state_t      state;
    state_t      state_nxt;

    logic [2:0]  idx;
    logic [6:0]  cnt_q;
    logic [2:0]  func_q;
    logic [63:0] data_q;
    logic        err_q;
    logic        vld_q;

    logic        req_legal;
    logic        din_fire;

    // byte generator signals
    logic        is_32;
    logic [6:0]  lim;
    logic        onehot_act;
    logic [6:0]  pos;
    logic [7:0]  byte_val;

    assign din_fire   = din_valid && (state == IDLE);
    assign dout_valid = vld_q;
    assign dout_data  = data_q;
    assign dout_err   = err_q;

    // Legality of the incoming request: full 7-bit unsigned compare against the word width,
    // so counts like 65..127 (bit 6 with nonzero low bits) are always rejected.
    always_comb begin
        req_legal = 1'b0;
        case (din_func)
            FN_CLZ64, FN_CTZ64, FN_CNT64: req_legal = (din_cnt <= 7'd64);
            FN_CLZ32, FN_CTZ32, FN_CNT32: req_legal = (din_cnt <= 7'd32);
            default:                      req_legal = 1'b0;
        endcase
    end

    // Byte idx of the result, derived only from the latched count and the byte index.
    // One-hot codes pick a target bit position and light it if it lands in this byte;
    // CNT compares the count's byte field against idx to pick full, partial or empty.
    always_comb begin
        is_32      = func_q[0];
        lim        = is_32 ? 7'd32 : 7'd64;
        onehot_act = (cnt_q < lim);
        pos        = cnt_q;
        byte_val   = 8'h00;
        case (func_q)
            FN_CLZ64: pos = 7'd63 - cnt_q;
            FN_CLZ32: pos = 7'd31 - cnt_q;
            default:  pos = cnt_q;
        endcase
        case (func_q)
            FN_CLZ64, FN_CLZ32, FN_CTZ64, FN_CTZ32: begin
                if (onehot_act && (pos[5:3] == idx)) begin
                    byte_val = 8'h01 << pos[2:0];
                end
            end
            FN_CNT64, FN_CNT32: begin
                if (cnt_q[6:3] > {1'b0, idx}) begin
                    byte_val = 8'hFF;
                end else if (cnt_q[6:3] == {1'b0, idx}) begin
                    byte_val = ~(8'hFF << cnt_q[2:0]);
                end else begin
                    byte_val = 8'h00;
                end
            end
            default: byte_val = 8'h00;
        endcase
    end

    // Next-state and handshake decode; din_ready depends on state alone.
    always_comb begin
        state_nxt = state;
        din_ready = 1'b0;
        case (state)
            IDLE: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    state_nxt = req_legal ? BUILD : DONE;
                end
            end
            BUILD: begin
                if (idx == 3'd7) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (dout_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and registered output-valid flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            vld_q <= 1'b0;
        end else begin
            state <= state_nxt;
            vld_q <= (state_nxt == DONE);
        end
    end

    // Request latch and serial byte-by-byte result assembly.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx    <= 3'd0;
            cnt_q  <= 7'd0;
            func_q <= 3'd0;
            data_q <= 64'd0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (din_fire) begin
                        cnt_q  <= din_cnt;
                        func_q <= din_func;
                        data_q <= 64'd0;
                        err_q  <= ~req_legal;
                        idx    <= 3'd0;
                    end
                end
                BUILD: begin
                    data_q[{idx, 3'b000} +: 8] <= byte_val;
                    idx                        <= idx + 3'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
